noncache_responder: RTL and testbench

- Target (responder) end of the core's non-cache load/store interface.
- Accepts one request at a time from a hart's noncache initiator port.
- Decodes the request against a local window of 64-bit registers, performs the byte-lane load or store, and returns data or an exception code after a fixed latency.
- Used as the MMIO/scratch device behind the noncache address range in single-core and test builds.

---
 rtl/noncache_responder.sv | 188 ++++++++++++++++++
 tb/tb_noncache_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noncache_responder.sv
// Responder end of the non-cache load/store interface: a window of 64-bit registers
// with byte-lane access and fixed response latency. Optional error counter: NONCACHE_RESP_ERRCNT_EN.
module noncache_responder #(
    parameter logic [47:0] BASE_ADDR = 48'h0000_1000_0000,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        noncache_req_rdy,
    input  logic        noncache_req_vld,
    input  logic [47:0] noncache_req_addr,
    input  logic [3:0]  noncache_req_len,
    input  logic        noncache_req_store,
    input  logic [63:0] noncache_req_data,
    input  logic        noncache_resp_rdy,
    output logic        noncache_resp_vld,
    output logic [7:0]  noncache_resp_expt,
    output logic [63:0] noncache_resp_data
`ifdef NONCACHE_RESP_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned WIN_BYTES = DEPTH * 8;
    localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [7:0]    resp_expt_q, resp_expt_d;
    logic [63:0]   resp_data_q, resp_data_d;

    logic          accept;
    logic [47:0]   off;
    logic          in_range;
    logic          aligned;
    logic [AW-1:0] word_sel;
    logic [2:0]    byte_sel;
    logic [7:0]    len_mask;
    logic [7:0]    lane_mask;
    logic [7:0]    req_expt;
    logic [63:0]   wdata_sh;
    logic [63:0]   rdata_sh;
    logic [63:0]   rdata;

    assign accept = noncache_req_vld && noncache_req_rdy;

    // Address decode, alignment and lane steering for the request on the bus
    always_comb begin
        off      = noncache_req_addr - BASE_ADDR;
        in_range = (noncache_req_addr >= BASE_ADDR) && (off < 48'(WIN_BYTES));
        word_sel = off[AW+2:3];
        byte_sel = off[2:0];
        len_mask = 8'h00;
        aligned  = 1'b0;
        case (noncache_req_len)
            4'b0001: begin len_mask = 8'h01; aligned = 1'b1;                 end
            4'b0010: begin len_mask = 8'h03; aligned = (byte_sel[0] == 1'b0);   end
            4'b0100: begin len_mask = 8'h0F; aligned = (byte_sel[1:0] == 2'b00); end
            4'b1000: begin len_mask = 8'hFF; aligned = (byte_sel == 3'b000);     end
            default: begin len_mask = 8'h00; aligned = 1'b0;                 end
        endcase
        if (!in_range) begin
            req_expt = 8'd1;
        end else if (!aligned) begin
            req_expt = 8'd2;
        end else begin
            req_expt = 8'd0;
        end
        lane_mask = len_mask << byte_sel;
        wdata_sh  = noncache_req_data << {byte_sel, 3'b000};
        rdata_sh  = mem_q[word_sel] >> {byte_sel, 3'b000};
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = len_mask[i] ? rdata_sh[8*i +: 8] : 8'h00;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (noncache_resp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        noncache_req_rdy  = (state_q == S_IDLE);
        noncache_resp_vld = (state_q == S_RESP);
    end

    assign noncache_resp_expt = resp_expt_q;
    assign noncache_resp_data = resp_data_q;

`ifdef NONCACHE_RESP_ERRCNT_EN
    logic [15:0] err_count_q, err_count_d;
    assign err_count = err_count_q;
`endif

    // Window access and response capture at the acceptance edge
    always_comb begin
        mem_d       = mem_q;
        resp_expt_d = resp_expt_q;
        resp_data_d = resp_data_q;
`ifdef NONCACHE_RESP_ERRCNT_EN
        err_count_d = err_count_q;
        if (accept && (req_expt != 8'd0) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
`endif
        if (accept) begin
            resp_expt_d = req_expt;
            resp_data_d = 64'd0;
            if (req_expt == 8'd0) begin
                if (noncache_req_store) begin
                    for (int i = 0; i < 8; i++) begin
                        if (lane_mask[i]) begin
                            mem_d[word_sel][8*i +: 8] = wdata_sh[8*i +: 8];
                        end
                    end
                end else begin
                    resp_data_d = rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 64'd0;
            end
            resp_expt_q <= 8'd0;
            resp_data_q <= 64'd0;
`ifdef NONCACHE_RESP_ERRCNT_EN
            err_count_q <= 16'd0;
`endif
        end else begin
            mem_q       <= mem_d;
            resp_expt_q <= resp_expt_d;
            resp_data_q <= resp_data_d;
`ifdef NONCACHE_RESP_ERRCNT_EN
            err_count_q <= err_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_noncache_responder.sv
// Self-checking bench for noncache_responder: directed cases plus random traffic
// compared against a byte-array model of the register window.
module tb_noncache_responder;

    localparam logic [47:0] BASE  = 48'h0000_1000_0000;
    localparam int          DEPTH = 64;
    localparam int          LAT   = 2;
    localparam int          WB    = DEPTH * 8;

    logic        clk;
    logic        rst;
    logic        noncache_req_rdy;
    logic        noncache_req_vld;
    logic [47:0] noncache_req_addr;
    logic [3:0]  noncache_req_len;
    logic        noncache_req_store;
    logic [63:0] noncache_req_data;
    logic        noncache_resp_rdy;
    logic        noncache_resp_vld;
    logic [7:0]  noncache_resp_expt;
    logic [63:0] noncache_resp_data;
`ifdef NONCACHE_RESP_ERRCNT_EN
    logic [15:0] err_count;
`endif

    noncache_responder #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH),
        .LATENCY  (LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .noncache_req_rdy  (noncache_req_rdy),
        .noncache_req_vld  (noncache_req_vld),
        .noncache_req_addr (noncache_req_addr),
        .noncache_req_len  (noncache_req_len),
        .noncache_req_store(noncache_req_store),
        .noncache_req_data (noncache_req_data),
        .noncache_resp_rdy (noncache_resp_rdy),
        .noncache_resp_vld (noncache_resp_vld),
        .noncache_resp_expt(noncache_resp_expt),
        .noncache_resp_data(noncache_resp_data)
`ifdef NONCACHE_RESP_ERRCNT_EN
        ,
        .err_count         (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mem_m [WB];
    int         err_m    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < WB; i++) mem_m[i] = 8'h00;
        err_m = 0;
    endtask

    // Reference: byte-addressed window, exceptions from the address/length rules
    task automatic model(input logic [47:0] a, input logic [3:0] l, input logic st,
                         input logic [63:0] d, output logic [7:0] ex, output logic [63:0] rd);
        logic [47:0] off;
        int nb;
        off = a - BASE;
        case (l)
            4'b0001: nb = 1;
            4'b0010: nb = 2;
            4'b0100: nb = 4;
            4'b1000: nb = 8;
            default: nb = 0;
        endcase
        rd = 64'd0;
        if (!(a >= BASE && off < 48'(WB)))        ex = 8'd1;
        else if (nb == 0 || (int'(off[2:0]) % nb) != 0) ex = 8'd2;
        else                                       ex = 8'd0;
        if (ex != 8'd0) begin
            err_m++;
        end else begin
            for (int k = 0; k < nb; k++) begin
                if (st) mem_m[int'(off) + k] = d[8*k +: 8];
                else    rd[8*k +: 8] = mem_m[int'(off) + k];
            end
        end
    endtask

    task automatic xact(input logic [47:0] a, input logic [3:0] l, input logic st,
                        input logic [63:0] d, input int hold, input string tag);
        logic [7:0]  ex;
        logic [63:0] ed;
        int n;
        model(a, l, st, d, ex, ed);
        @(negedge clk);
        noncache_req_vld   = 1'b1;
        noncache_req_addr  = a;
        noncache_req_len   = l;
        noncache_req_store = st;
        noncache_req_data  = d;
        noncache_resp_rdy  = 1'b0;
        n = 0;
        while (!noncache_req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!noncache_req_rdy) begin
            check({tag, "_accept_timeout"}, 64'(noncache_req_rdy), 64'd1);
            noncache_req_vld = 1'b0;
            return;
        end
        @(negedge clk);
        noncache_req_vld = 1'b0;
        n = 1;
        while (!noncache_resp_vld && n < 50) begin
            check({tag, "_rdy_busy"}, 64'(noncache_req_rdy), 64'd0);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        if (!noncache_resp_vld) return;
        for (int h = 0; h <= hold; h++) begin
            check({tag, "_vld"},  64'(noncache_resp_vld),  64'd1);
            check({tag, "_expt"}, 64'(noncache_resp_expt), 64'(ex));
            check({tag, "_data"}, noncache_resp_data, ed);
            check({tag, "_rdy_resp"}, 64'(noncache_req_rdy), 64'd0);
            if (h < hold) @(negedge clk);
        end
        noncache_resp_rdy = 1'b1;
        @(negedge clk);
        noncache_resp_rdy = 1'b0;
        check({tag, "_vld_after"}, 64'(noncache_resp_vld), 64'd0);
        check({tag, "_rdy_after"}, 64'(noncache_req_rdy), 64'd1);
`ifdef NONCACHE_RESP_ERRCNT_EN
        check({tag, "_errcnt"}, 64'(err_count), 64'(err_m));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  ex;
        logic [63:0] ed;
        int acc, rsp, last;
        rst                = 1'b1;
        noncache_req_vld   = 1'b0;
        noncache_req_addr  = 48'd0;
        noncache_req_len   = 4'd0;
        noncache_req_store = 1'b0;
        noncache_req_data  = 64'd0;
        noncache_resp_rdy  = 1'b0;
        clear_model();
        #12;
        check("reset_rdy",  64'(noncache_req_rdy),   64'd1);
        check("reset_vld",  64'(noncache_resp_vld),  64'd0);
        check("reset_expt", 64'(noncache_resp_expt), 64'd0);
        check("reset_data", noncache_resp_data,      64'd0);
        @(negedge clk);
        rst = 1'b0;

        xact(BASE + 48'd8,  4'b1000, 1'b1, 64'h1122_3344_5566_7788, 0, "st8");
        xact(BASE + 48'd8,  4'b1000, 1'b0, 64'd0, 0, "ld8");
        xact(BASE + 48'd11, 4'b0001, 1'b1, 64'h0000_0000_0000_00AB, 0, "st1");
        xact(BASE + 48'd8,  4'b1000, 1'b0, 64'd0, 0, "ld8_merged");
        xact(BASE + 48'd10, 4'b0010, 1'b0, 64'd0, 0, "ld2");
        xact(BASE + 48'd2,  4'b0100, 1'b0, 64'd0, 0, "ld4_misalign");
        xact(BASE + 48'(WB), 4'b0100, 1'b1, 64'hDEAD_BEEF, 0, "st4_oob");
        xact(BASE + 48'd8,  4'b1000, 1'b0, 64'd0, 0, "ld8_unchanged");
        xact(BASE + 48'd8,  4'b1000, 1'b0, 64'd0, 5, "ld8_hold5");

        // Reset while the response is still pending
        @(negedge clk);
        noncache_req_vld   = 1'b1;
        noncache_req_addr  = BASE;
        noncache_req_len   = 4'b1000;
        noncache_req_store = 1'b1;
        noncache_req_data  = 64'h0000_0000_0000_FFFF;
        @(posedge clk);
        #2;
        check("rst_pre_rdy", 64'(noncache_req_rdy), 64'd0);
        rst = 1'b1;
        #1;
        check("rst_async_vld", 64'(noncache_resp_vld), 64'd0);
        check("rst_async_rdy", 64'(noncache_req_rdy),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        noncache_req_vld = 1'b0;
        clear_model();
        xact(BASE, 4'b1000, 1'b0, 64'd0, 0, "ld_after_rst");

        // Continuous requests with the response always taken
        xact(BASE + 48'd16, 4'b1000, 1'b1, 64'hCAFE_F00D_0123_4567, 0, "burst_setup");
        model(BASE + 48'd16, 4'b1000, 1'b0, 64'd0, ex, ed);
        @(negedge clk);
        noncache_req_vld   = 1'b1;
        noncache_req_addr  = BASE + 48'd16;
        noncache_req_len   = 4'b1000;
        noncache_req_store = 1'b0;
        noncache_resp_rdy  = 1'b1;
        acc = 0; rsp = 0; last = -1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (noncache_req_vld && noncache_req_rdy) begin
                acc++;
                if (last >= 0) check("burst_gap", 64'(cyc - last), 64'(LAT + 1));
                last = cyc;
            end
            if (noncache_resp_vld && noncache_resp_rdy) begin
                rsp++;
                check("burst_data", noncache_resp_data, ed);
            end
            if (cyc == 29) noncache_req_vld = 1'b0;
            @(negedge clk);
        end
        noncache_resp_rdy = 1'b0;
        check("burst_acc_nonzero", 64'(acc > 0), 64'd1);
        check("burst_acc_eq_rsp", 64'(rsp), 64'(acc));
`ifdef NONCACHE_RESP_ERRCNT_EN
        for (int i = 1; i < acc; i++) model(BASE + 48'd16, 4'b1000, 1'b0, 64'd0, ex, ed);
`endif

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            logic [47:0] a;
            logic [3:0]  l;
            int r;
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 9) < 8) l = 4'(1 << $urandom_range(0, 3));
            else                         l = 4'($urandom);
            case (r)
                0: a = BASE - 48'($urandom_range(1, 16));
                1: a = BASE + 48'(WB) + 48'($urandom_range(0, 16));
                2: a = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
                default: begin
                    a = BASE + 48'($urandom_range(0, WB - 1));
                    if (r > 4) a[2:0] = 3'b000;
                end
            endcase
            xact(a, l, 1'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
